// File: rtl/tcam_match_encoder.sv
// Two-stage pipelined priority encoder for a TCAM match vector: chunk-local
// encoding in stage 1, chunk selection into registered outputs in stage 2.
module tcam_match_encoder #(
    parameter int K     = 256,
    parameter int C     = 32,
    parameter int CNT_W = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_valid,
    output logic                       o_ready,
    input  logic [0:K-1]               i_pma,
    output logic                       o_valid,
    input  logic                       i_ready,
    output logic                       o_hit,
    output logic [$clog2(K)-1:0]       o_addr,
    output logic                       o_multi,
    input  logic                       i_cnt_clr,
    output logic [CNT_W-1:0]           o_hit_cnt
);

    localparam int AW  = $clog2(K);
    localparam int NCH = K / C;
    localparam int LW  = $clog2(C);
    localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;

    // Handshake: a beat moves when valid & ready are both high on a rising
    // edge; o_valid and the result fields stay frozen until i_ready accepts.
    logic in_xfer, out_xfer, s1_adv, s2_en;

    logic                    s1_valid;
    logic [NCH-1:0]          s1_hit;
    logic [NCH-1:0]          s1_multi;
    logic [NCH-1:0][LW-1:0]  s1_idx;

    logic [NCH-1:0]          c_hit;
    logic [NCH-1:0]          c_multi;
    logic [NCH-1:0][LW-1:0]  c_idx;

    logic                    sel_any;
    logic                    sel_multi;
    logic [CW-1:0]           sel_chunk;
    logic [LW-1:0]           sel_idx;
    logic [AW-1:0]           sel_addr;

    assign s2_en    = !o_valid || i_ready;
    assign s1_adv   = !s1_valid || s2_en;
    assign o_ready  = s1_adv;
    assign in_xfer  = i_valid && o_ready;
    assign out_xfer = o_valid && i_ready;

    // Per-chunk encode: scan high to low so the lowest set bit wins the index.
    always_comb begin : chunk_enc
        logic seen;
        logic mult;
        c_hit   = '0;
        c_multi = '0;
        c_idx   = '0;
        for (int j = 0; j < NCH; j++) begin
            seen = 1'b0;
            mult = 1'b0;
            for (int b = C - 1; b >= 0; b--) begin
                if (i_pma[j*C + b]) begin
                    mult     = mult | seen;
                    seen     = 1'b1;
                    c_idx[j] = LW'(b);
                end
            end
            c_hit[j]   = seen;
            c_multi[j] = mult;
        end
    end

    // Chunk select: scan high to low; any earlier-seen hit lies in a
    // higher-numbered chunk and therefore makes the result a multi-match.
    always_comb begin
        sel_any   = 1'b0;
        sel_multi = 1'b0;
        sel_chunk = '0;
        sel_idx   = '0;
        for (int j = NCH - 1; j >= 0; j--) begin
            if (s1_hit[j]) begin
                sel_multi = s1_multi[j] | sel_any;
                sel_any   = 1'b1;
                sel_chunk = CW'(j);
                sel_idx   = s1_idx[j];
            end
        end
        sel_addr = (AW'(sel_chunk) << LW) | AW'(sel_idx);
    end

    // Stage-1 data only loads on an input transfer, so idle X never enters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_hit   <= '0;
            s1_multi <= '0;
            s1_idx   <= '0;
        end else if (s1_adv) begin
            s1_valid <= in_xfer;
            if (in_xfer) begin
                s1_hit   <= c_hit;
                s1_multi <= c_multi;
                s1_idx   <= c_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_valid <= 1'b0;
            o_hit   <= 1'b0;
            o_addr  <= '0;
            o_multi <= 1'b0;
        end else if (s2_en) begin
            o_valid <= s1_valid;
            if (s1_valid) begin
                o_hit   <= sel_any;
                o_addr  <= sel_addr;
                o_multi <= sel_multi;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_hit_cnt <= '0;
        end else if (i_cnt_clr) begin
            o_hit_cnt <= '0;
        end else if (out_xfer && o_hit && (o_hit_cnt != {CNT_W{1'b1}})) begin
            o_hit_cnt <= o_hit_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_tcam_match_encoder.sv
// Directed bench for tcam_match_encoder: vector table, counter, backpressure
// and mid-flight reset sequences, built with a 4-bit hit counter.
module tb_tcam_match_encoder;

    localparam int K     = 256;
    localparam int C     = 32;
    localparam int CNT_W = 4;
    localparam int AW    = $clog2(K);
    localparam int W     = AW + 2;

    logic              clk;
    logic              rst_n;
    logic              i_valid;
    logic              o_ready;
    logic [0:K-1]      i_pma;
    logic              o_valid;
    logic              i_ready;
    logic              o_hit;
    logic [AW-1:0]     o_addr;
    logic              o_multi;
    logic              i_cnt_clr;
    logic [CNT_W-1:0]  o_hit_cnt;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [0:K-1]  pma;
        logic          hit;
        logic [AW-1:0] addr;
        logic          multi;
    } vec_t;

    vec_t           tab[8];
    logic [W-1:0]   exp_q[$];
    logic [0:K-1]   bp_vec[4];

    tcam_match_encoder #(.K(K), .C(C), .CNT_W(CNT_W)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .i_pma     (i_pma),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_hit     (o_hit),
        .o_addr    (o_addr),
        .o_multi   (o_multi),
        .i_cnt_clr (i_cnt_clr),
        .o_hit_cnt (o_hit_cnt)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [0:K-1] mk(int a, int b, int c);
        logic [0:K-1] v;
        v = '0;
        if (a >= 0) v[a] = 1'b1;
        if (b >= 0) v[b] = 1'b1;
        if (c >= 0) v[c] = 1'b1;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // driver: one vector with i_ready high, checks 2-cycle latency and drain
    task automatic run_vec(input logic [0:K-1] v, input logic hit, input logic [AW-1:0] addr,
                           input logic multi, input logic clr, input string tag);
        @(negedge clk);
        i_valid = 1'b1;
        i_pma   = v;
        i_ready = 1'b1;
        @(negedge clk);
        i_valid = 1'b0;
        i_pma   = '0;
        chk({tag, "_lat1_valid"}, 32'(o_valid), 32'd0);
        @(negedge clk);
        chk({tag, "_valid"}, 32'(o_valid), 32'd1);
        chk({tag, "_hit"},   32'(o_hit),   32'(hit));
        chk({tag, "_addr"},  32'(o_addr),  32'(addr));
        chk({tag, "_multi"}, 32'(o_multi), 32'(multi));
        i_cnt_clr = clr;
        @(negedge clk);
        i_cnt_clr = 1'b0;
        chk({tag, "_drain"}, 32'(o_valid), 32'd0);
    endtask

    initial begin
        int sent;
        int got;
        logic          stall_prev;
        logic [W-1:0]  prev_out;
        logic [W-1:0]  cur;
        logic [W-1:0]  e;

        tab[0] = '{mk(0, -1, -1),    1'b1, 8'd0,   1'b0};
        tab[1] = '{mk(31, -1, -1),   1'b1, 8'd31,  1'b0};
        tab[2] = '{mk(32, -1, -1),   1'b1, 8'd32,  1'b0};
        tab[3] = '{mk(255, -1, -1),  1'b1, 8'd255, 1'b0};
        tab[4] = '{mk(5, 40, 200),   1'b1, 8'd5,   1'b1};
        tab[5] = '{mk(33, 34, -1),   1'b1, 8'd33,  1'b1};
        tab[6] = '{mk(-1, -1, -1),   1'b0, 8'd0,   1'b0};
        tab[7] = '{mk(63, 64, -1),   1'b1, 8'd63,  1'b1};

        rst_n = 1'b0; i_valid = 1'b0; i_pma = '0; i_ready = 1'b1; i_cnt_clr = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_valid", 32'(o_valid),   32'd0);
        chk("rst_hit",   32'(o_hit),     32'd0);
        chk("rst_addr",  32'(o_addr),    32'd0);
        chk("rst_multi", 32'(o_multi),   32'd0);
        chk("rst_cnt",   32'(o_hit_cnt), 32'd0);
        chk("rst_ready", 32'(o_ready),   32'd1);

        for (int i = 0; i < 8; i++)
            run_vec(tab[i].pma, tab[i].hit, tab[i].addr, tab[i].multi, 1'b0, $sformatf("tab%0d", i));
        chk("cnt_after_table", 32'(o_hit_cnt), 32'd7);

        @(negedge clk); i_cnt_clr = 1'b1;
        @(negedge clk); i_cnt_clr = 1'b0;
        chk("cnt_clear", 32'(o_hit_cnt), 32'd0);

        run_vec(mk(10, -1, -1), 1'b1, 8'd10, 1'b0, 1'b0, "c_h1");
        run_vec(mk(-1, -1, -1), 1'b0, 8'd0,  1'b0, 1'b0, "c_miss");
        run_vec(mk(99, 150, -1), 1'b1, 8'd99, 1'b1, 1'b0, "c_h2");
        run_vec(mk(128, -1, -1), 1'b1, 8'd128, 1'b0, 1'b0, "c_h3");
        chk("cnt_3hits_1miss", 32'(o_hit_cnt), 32'd3);
        run_vec(mk(1, -1, -1), 1'b1, 8'd1, 1'b0, 1'b1, "c_clr_hit");
        chk("cnt_clr_beats_inc", 32'(o_hit_cnt), 32'd0);

        // backpressure: 4 back-to-back vectors, i_ready low for cycles 2..6
        bp_vec[0] = mk(7, -1, -1);
        bp_vec[1] = mk(64, 65, -1);
        bp_vec[2] = mk(-1, -1, -1);
        bp_vec[3] = mk(200, 255, -1);
        exp_q.push_back({1'b1, 8'd7,   1'b0});
        exp_q.push_back({1'b1, 8'd64,  1'b1});
        exp_q.push_back({1'b0, 8'd0,   1'b0});
        exp_q.push_back({1'b1, 8'd200, 1'b1});
        sent = 0; got = 0; stall_prev = 1'b0; prev_out = '0;
        for (int t = 0; t < 40 && (sent < 4 || got < 4); t++) begin
            @(negedge clk);
            i_ready = !(t >= 2 && t < 7);
            if (sent < 4) begin
                i_valid = 1'b1;
                i_pma   = bp_vec[sent];
            end else begin
                i_valid = 1'b0;
                i_pma   = 'x;
            end
            #1;
            cur = {o_hit, o_addr, o_multi};
            if (t == 2) chk("bp_ready_low_2held", 32'(o_ready), 32'd0);
            if (o_valid && stall_prev) chk("bp_stable", 32'(cur), 32'(prev_out));
            if (o_valid && i_ready) begin
                if (exp_q.size() == 0) begin
                    chk("bp_extra_result", 32'(got), 32'd4);
                end else begin
                    e = exp_q.pop_front();
                    chk($sformatf("bp_res%0d", got), 32'(cur), 32'(e));
                end
                got++;
            end
            stall_prev = o_valid && !i_ready;
            prev_out   = cur;
            if (i_valid && o_ready) sent++;
        end
        chk("bp_all_delivered", 32'(got), 32'd4);
        chk("bp_queue_empty", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        i_valid = 1'b0; i_pma = '0; i_ready = 1'b1;
        @(negedge clk);
        chk("bp_cnt", 32'(o_hit_cnt), 32'd3);

        for (int i = 0; i < 20; i++)
            run_vec(mk(i * 13, -1, -1), 1'b1, AW'(i * 13), 1'b0, 1'b0, "sat");
        chk("cnt_saturated", 32'(o_hit_cnt), 32'd15);

        // reset with two vectors held in the pipe
        @(negedge clk); i_ready = 1'b0; i_valid = 1'b1; i_pma = mk(20, -1, -1);
        @(negedge clk); i_pma = mk(21, -1, -1);
        @(negedge clk); i_valid = 1'b0; i_pma = '0;
        chk("mid_pipe_full_valid", 32'(o_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(o_valid),   32'd0);
        chk("mid_rst_cnt",   32'(o_hit_cnt), 32'd0);
        @(negedge clk); rst_n = 1'b1; i_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("mid_no_stale%0d", i), 32'(o_valid), 32'd0);
        end
        run_vec(mk(77, 90, -1), 1'b1, 8'd77, 1'b1, 1'b0, "post_rst");
        chk("post_rst_cnt", 32'(o_hit_cnt), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tcam_match_encoder.md
Name: tcam_match_encoder

Overview:
- Downstream stage of the TCAM layer; consumes the K-bit prioritised match vector (PMA) and produces a binary match address, hit flag and multi-match flag.
- Two-stage valid/ready pipeline with full throughput and backpressure, so the search datapath can be retimed without a combinational K-wide encoder.
- Also keeps a saturating hit counter for statistics readout.

Parameters:
- K, 256, number of TCAM entries (PMA width); power of two, 64..1024.
- C, 32, chunk width for stage-1 local encoding; power of two, divides K.
- AW, $clog2(K), match address width (derived, not overridable).
- CNT_W, 32, hit counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- i_valid  in  1  PMA vector valid.
- o_ready  out  1  encoder can accept a vector this cycle.
- i_pma  in  [0:K-1]  match vector; bit 0 is entry 0, the highest priority.
- o_valid  out  1  result valid.
- i_ready  in  1  consumer accepts result.
- o_hit  out  1  at least one PMA bit was set.
- o_addr  out  AW  index of lowest-numbered set bit; 0 when o_hit=0.
- o_multi  out  1  two or more PMA bits were set.
- i_cnt_clr  in  1  synchronous clear of the hit counter.
- o_hit_cnt  out  CNT_W  number of hit results accepted downstream, saturating.

Behaviour:
- Reset: all of the following are cleared: o_valid, o_hit, o_addr, o_multi, o_hit_cnt, and the stage-1 valid bit and data. o_ready=1 while rst_n is high after reset.
- Transfers:
  - Input transfer on i_valid & o_ready.
  - Output transfer on o_valid & i_ready.
- Stage 1, registered on input transfer:
  - Split i_pma into K/C chunks; chunk j covers bits j*C..j*C+C-1.
  - Store per chunk: any-hit bit, local index (lowest set bit within the chunk, width $clog2(C)), and a local-multi bit (two or more set bits in the chunk).
- Stage 2, registered into the outputs:
  - Select the lowest j whose chunk has a hit.
  - o_addr = j*C + local index.
  - o_hit = OR of all chunk hit bits.
  - o_multi = (selected chunk local-multi) OR (any higher-numbered chunk has a hit).
- Latency: exactly 2 cycles from input transfer to o_valid when there is no backpressure. Throughput is one vector per cycle.
- Backpressure:
  - Stage 2 loads when !o_valid | i_ready.
  - Stage 1 advances under the same condition, or when stage 1 is empty.
  - o_ready = !s1_valid | !o_valid | i_ready. This is combinational from i_ready; no other comb path from input to output.
  - With i_ready held low, the pipe holds at most 2 vectors. Output values stay stable while o_valid & !i_ready.
- No hit: o_hit=0, o_addr=0, o_multi=0, o_valid still asserted. A miss is a valid result.
- Counter:
  - Increments on output transfer with o_hit=1.
  - Saturates at 2^CNT_W-1.
  - i_cnt_clr takes priority over an increment in the same cycle; the counter ends at 0.
- Reset mid-operation drops all in-flight vectors; no result is emitted for them.
- X on i_pma while i_valid=0 must not propagate into the registers; stage-1 data is enabled only on input transfer.

Test Plan:
- Single-hit sweep: K=256, send i_pma with only bit i set for i=0,31,32,255, i_ready=1 -> o_addr=i, o_hit=1, o_multi=0, each result 2 cycles after its input.
- Priority: bits 5, 40 and 200 set -> o_addr=5, o_multi=1. Bits 33 and 34 set -> o_addr=33, o_multi=1 (multi within one chunk).
- Miss: all-zero vector -> o_valid=1, o_hit=0, o_addr=0, o_multi=0; o_hit_cnt unchanged.
- Backpressure: stream 4 back-to-back vectors, hold i_ready=0 for 5 cycles starting cycle 2 -> o_ready falls after 2 vectors are held, outputs stable while stalled, all 4 results delivered in order with no loss or duplication after i_ready returns.
- Counter: 3 hits and 1 miss accepted -> o_hit_cnt=3. Assert i_cnt_clr in the same cycle as a hit transfer -> o_hit_cnt=0. Preload near max (CNT_W=4 build) with 20 hits -> o_hit_cnt=15.
- Reset mid-flight: assert rst_n=0 asynchronously with 2 vectors in the pipe -> o_valid=0 immediately, o_hit_cnt=0; after release, no stale result appears and the next input yields the correct result.
